// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bit stream out.
// Build with SER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sout_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             first_r;
    logic             last;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_r;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        last        = 1'b0;
        state_nxt   = state;
        sout        = 1'b0;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        if (sout_en) begin
`ifdef SER_PARITY_EN
            last = (state == PAR);
`else
            last = (state == SHIFT) && (cnt == '0);
`endif
        end
        // Ready during the final bit lets the next word follow with no idle gap.
        din_ready = (state == IDLE) || last;
        accept    = din_valid && din_ready;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                sout        = shreg[WIDTH-1];
                sout_valid  = sout_en;
                frame_start = sout_en && first_r;
                if (sout_en && (cnt == '0)) begin
`ifdef SER_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                sout       = par_r;
                sout_valid = sout_en;
                if (sout_en) state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            first_r <= 1'b0;
`ifdef SER_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg   <= din;
                cnt     <= CNT_W'(WIDTH - 1);
                first_r <= 1'b1;
`ifdef SER_PARITY_EN
                par_r   <= ^din;
`endif
            end else if ((state == SHIFT) && sout_en) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                first_r <= 1'b0;
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a queue of expected (bit, first) pairs is filled on every
// modelled accept and drained as the DUT emits valid bits.
module tb_bit_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef struct {
        logic b;
        logic f;
    } exp_bit_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout_en;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             busy;

    exp_bit_t    q[$];
    int          checks   = 0;
    int          failures = 0;
    int          vcnt;
    int          first_t;
    int          last_t;
    int          cycn     = 0;
    logic        last_acc;
    logic [31:0] cap;

    bit_serializer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout_en(sout_en), .sout(sout), .sout_valid(sout_valid),
        .frame_start(frame_start), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SER_PARITY_EN
        return {23'd0, w, ^w};
`else
        return {24'd0, w};
`endif
    endfunction

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back('{b: w[i], f: (i == WIDTH - 1)});
`ifdef SER_PARITY_EN
        q.push_back('{b: ^w, f: 1'b0});
`endif
    endtask

    // One clock: compare at the falling edge, update the model for the coming rising edge.
    task automatic cyc();
        exp_bit_t e;
        logic     exp_ready;
        @(negedge clk);
        exp_ready = (q.size() == 0) || ((q.size() == 1) && sout_en);
        check("din_ready", din_ready, exp_ready);
        check("busy", busy, q.size() != 0);
        check("sout_valid", sout_valid, (q.size() != 0) && sout_en);
        if ((q.size() != 0) && sout_en) begin
            e = q.pop_front();
            check("sout", sout, e.b);
            check("frame_start", frame_start, e.f);
        end else if (q.size() == 0) begin
            check("sout_idle", sout, 1'b0);
        end
        if (sout_valid === 1'b1) begin
            vcnt++;
            if (first_t < 0) first_t = cycn;
            last_t = cycn;
            cap = {cap[30:0], sout};
        end
        last_acc = rst && din_valid && exp_ready;
        if (!rst) q.delete();
        else if (last_acc) push_word(din);
        cycn++;
        @(posedge clk);
        #1;
    endtask

    task automatic window();
        vcnt    = 0;
        first_t = -1;
        last_t  = -1;
        cap     = '0;
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input bit keep);
        logic got;
        got       = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            got = last_acc;
        end
        check("accept_timeout", got, 1'b1);
        if (!keep) din_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) cyc();
        check("drain_timeout", q.size(), 0);
        cyc();
        cyc();
    endtask

    initial begin
        rst       = 1'b0;
        din       = 8'h55;
        din_valid = 1'b1;
        sout_en   = 1'b1;
        window();
        @(posedge clk);
        #1;
        // Reset held with valid asserted: nothing may be accepted.
        cyc();
        cyc();
        check("rst_vcnt", vcnt, 0);
        rst       = 1'b1;
        din_valid = 1'b0;
        cyc();

        // Single word.
        window();
        send(8'h92, 1'b0);
        drain();
        check("single_bits", cap & ((32'h1 << FRAME) - 1), frame_of(8'h92));
        check("single_vcnt", vcnt, FRAME);
        check("single_span", last_t - first_t + 1, FRAME);

        // Back-to-back words must stream without a gap.
        window();
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b0);
        drain();
        check("b2b_bits", cap & ((32'h1 << (2 * FRAME)) - 1),
              (frame_of(8'hA5) << FRAME) | frame_of(8'h3C));
        check("b2b_vcnt", vcnt, 2 * FRAME);
        check("b2b_span", last_t - first_t + 1, 2 * FRAME);

        // Throttled enable 1,0,1,0...
        window();
        send(8'hF0, 1'b0);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            cyc();
            sout_en = ~sout_en;
        end
        sout_en = 1'b1;
        drain();
        check("thr_bits", cap & ((32'h1 << FRAME) - 1), frame_of(8'hF0));
        check("thr_vcnt", vcnt, FRAME);
        check("thr_span", last_t - first_t + 1, 2 * FRAME - 1);

        // Reset mid-word aborts the frame.
        window();
        send(8'hFF, 1'b0);
        cyc();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_sout", sout, 1'b0);
        check("midrst_valid", sout_valid, 1'b0);
        @(posedge clk);
        #1;
        window();
        send(8'h81, 1'b0);
        drain();
        check("after_rst_bits", cap & ((32'h1 << FRAME) - 1), frame_of(8'h81));
        check("after_rst_vcnt", vcnt, FRAME);

        // Stream that feeds the pattern detector.
        window();
        send(8'h92, 1'b1);
        send(8'h00, 1'b0);
        drain();
        check("chain_bits", cap & ((32'h1 << (2 * FRAME)) - 1),
              (frame_of(8'h92) << FRAME) | frame_of(8'h00));
        check("chain_span", last_t - first_t + 1, 2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
